pulsegen_seq_ctrl: RTL and testbench

Sequence controller for the pulse generator IP. Holds a small table of pulse steps (high time, low time, repeat count) written from the AXI4-Lite register bank, then, on a start command, plays the table out as a cycle-exact waveform on `pulse_out` with zero-bubble step transitions. It sits between the AXI slave register file and the output pin, and reports `busy`, `done` and the current step back to the status registers.

---
 rtl/pulsegen_pkg.sv | 29 ++
 rtl/pulsegen_seq_ctrl_if.sv | 29 ++
 rtl/pulsegen_step_table.sv | 43 ++++
 rtl/pulsegen_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_pulsegen_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pulsegen_pkg.sv
// rtl/pulsegen_pkg.sv - shared types, field codes and helpers for the pulse sequencer
package pulsegen_pkg;

  localparam int PG_NUM_STEPS = 8;
  localparam int PG_CNT_W     = 16;
  localparam int PG_REP_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [1:0] CFG_HIGH = 2'd0;
  localparam logic [1:0] CFG_LOW  = 2'd1;
  localparam logic [1:0] CFG_REP  = 2'd2;

  typedef struct packed {
    logic [PG_CNT_W-1:0] hi;
    logic [PG_CNT_W-1:0] lo;
    logic [PG_REP_W-1:0] rep;
  } step_t;

  // A step that would produce no waveform cycles ends the sequence.
  function automatic logic is_term(input step_t s);
    return (s.rep == '0) || ((s.hi == '0) && (s.lo == '0));
  endfunction

endpackage

// File: rtl/pulsegen_seq_ctrl_if.sv
// rtl/pulsegen_seq_ctrl_if.sv - table write, run control and status bundle
interface pulsegen_seq_ctrl_if #(
  parameter int NUM_STEPS = pulsegen_pkg::PG_NUM_STEPS
);

  logic                         cfg_we;
  logic [$clog2(NUM_STEPS)-1:0] cfg_step;
  logic [1:0]                   cfg_field;
  logic [31:0]                  cfg_wdata;
  logic                         start;
  logic                         abort;
  logic                         loop_en;
  logic                         pulse_out;
  logic                         busy;
  logic                         done;
  logic [$clog2(NUM_STEPS)-1:0] cur_step;
  logic                         cfg_err;

  modport master (
    output cfg_we, cfg_step, cfg_field, cfg_wdata, start, abort, loop_en,
    input  pulse_out, busy, done, cur_step, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_step, cfg_field, cfg_wdata, start, abort, loop_en,
    output pulse_out, busy, done, cur_step, cfg_err
  );

endinterface

// File: rtl/pulsegen_step_table.sv
// rtl/pulsegen_step_table.sv - step register array with one field write port and async reads
module pulsegen_step_table
  import pulsegen_pkg::*;
#(
  parameter int NUM_STEPS = PG_NUM_STEPS,
  parameter int CNT_W     = PG_CNT_W,
  parameter int REP_W     = PG_REP_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_idx,
  input  logic [1:0]                   field,
  input  logic [31:0]                  wdata,
  input  logic [$clog2(NUM_STEPS)-1:0] rd_idx,
  output step_t                        rd_data,
  output step_t                        step0
);

  step_t tbl [NUM_STEPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl[i] <= '0;
      end
    end else if (we) begin
      case (field)
        CFG_HIGH: tbl[wr_idx].hi  <= wdata[CNT_W-1:0];
        CFG_LOW:  tbl[wr_idx].lo  <= wdata[CNT_W-1:0];
        CFG_REP:  tbl[wr_idx].rep <= wdata[REP_W-1:0];
        default:  ;
      endcase
    end
  end

  assign rd_data = tbl[rd_idx];
  // Entry 0 is exposed separately so a loop wrap can reload it while rd_idx points past the end.
  assign step0   = tbl[0];

  wire unused_wdata = ^wdata[31:CNT_W];

endmodule

// File: rtl/pulsegen_seq_ctrl.sv
// rtl/pulsegen_seq_ctrl.sv - plays the step table out as a cycle-exact pulse waveform
module pulsegen_seq_ctrl
  import pulsegen_pkg::*;
#(
  parameter int NUM_STEPS = PG_NUM_STEPS,
  parameter int CNT_W     = PG_CNT_W,
  parameter int REP_W     = PG_REP_W
) (
  input  logic           ACLK,
  input  logic           ARESETN,
  pulsegen_seq_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n, rd_idx;
  logic [CNT_W-1:0] ph_cnt, ph_n;
  logic [REP_W-1:0] rep_cnt, rep_n;
  step_t            cur_q, cur_n, rd_data, step0, ld;
  logic             load, term_q, term_n, done_n, cfg_err_n, running;
  logic             pulse_q, busy_q, done_q, cfg_err_q;

  assign running   = (state != S_IDLE);
  assign rd_idx    = running ? idx + 1'b1 : '0;
  assign cfg_err_n = bus.cfg_we && (bus.cfg_field != 2'd3) && running;

  pulsegen_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .CNT_W     (CNT_W),
    .REP_W     (REP_W)
  ) u_table (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .we      (bus.cfg_we && !running),
    .wr_idx  (bus.cfg_step),
    .field   (bus.cfg_field),
    .wdata   (bus.cfg_wdata),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .step0   (step0)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    ph_n    = ph_cnt;
    rep_n   = rep_cnt;
    cur_n   = cur_q;
    term_n  = term_q;
    done_n  = 1'b0;
    load    = 1'b0;
    ld      = rd_data;
    case (state)
      S_IDLE: begin
        term_n = 1'b0;
        if (bus.start && !bus.abort) begin
          if (is_term(rd_data)) begin
            // Empty sequence still shows one busy cycle before done.
            state_n = S_LOW;
            term_n  = 1'b1;
            ph_n    = '0;
            rep_n   = '0;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_HIGH, S_LOW: begin
        if (bus.abort) begin
          state_n = S_IDLE;
          idx_n   = '0;
          term_n  = 1'b0;
        end else if (term_q) begin
          state_n = S_IDLE;
          idx_n   = '0;
          term_n  = 1'b0;
          done_n  = 1'b1;
        end else if (ph_cnt != '0) begin
          ph_n = ph_cnt - 1'b1;
        end else if ((state == S_HIGH) && (cur_q.lo != '0)) begin
          state_n = S_LOW;
          ph_n    = cur_q.lo - 1'b1;
        end else if (rep_cnt != '0) begin
          rep_n = rep_cnt - 1'b1;
          if (cur_q.hi != '0) begin
            state_n = S_HIGH;
            ph_n    = cur_q.hi - 1'b1;
          end else begin
            state_n = S_LOW;
            ph_n    = cur_q.lo - 1'b1;
          end
        end else if ((idx != LAST_IDX) && !is_term(rd_data)) begin
          load  = 1'b1;
          idx_n = idx + 1'b1;
        end else if (bus.loop_en && !is_term(step0)) begin
          load  = 1'b1;
          ld    = step0;
          idx_n = '0;
        end else begin
          state_n = S_IDLE;
          idx_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
        term_n  = 1'b0;
      end
    endcase
    // Loading a step enters its first phase directly, so step changes cost no cycle.
    if (load) begin
      cur_n = ld;
      rep_n = ld.rep - 1'b1;
      if (ld.hi != '0) begin
        state_n = S_HIGH;
        ph_n    = ld.hi - 1'b1;
      end else begin
        state_n = S_LOW;
        ph_n    = ld.lo - 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      idx       <= '0;
      ph_cnt    <= '0;
      rep_cnt   <= '0;
      cur_q     <= '0;
      term_q    <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      ph_cnt    <= ph_n;
      rep_cnt   <= rep_n;
      cur_q     <= cur_n;
      term_q    <= term_n;
      pulse_q   <= (state_n == S_HIGH);
      busy_q    <= (state_n != S_IDLE);
      done_q    <= done_n;
      cfg_err_q <= cfg_err_n;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cur_step  = idx;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pulsegen_seq_ctrl.sv
// tb/tb_pulsegen_seq_ctrl.sv - directed vector bench for pulsegen_seq_ctrl
module tb_pulsegen_seq_ctrl;

  logic ACLK = 1'b0;
  logic ARESETN;
  int   checks = 0;
  int   errors = 0;

  pulsegen_seq_ctrl_if #(.NUM_STEPS(8)) bus ();

  pulsegen_seq_ctrl #(
    .NUM_STEPS (8),
    .CNT_W     (16),
    .REP_W     (8)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        start;
    logic        abort;
    logic        loop_en;
    logic        we;
    logic [1:0]  field;
    logic [31:0] wdata;
    logic        e_pulse;
    logic        e_busy;
    logic        e_done;
    logic [2:0]  e_step;
    logic        e_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input int st, input int ab, input int lp, input int we,
                             input int fld, input int wd, input int ep, input int eb,
                             input int ed, input int es, input int ee);
    vec_t r;
    r.start   = st[0];
    r.abort   = ab[0];
    r.loop_en = lp[0];
    r.we      = we[0];
    r.field   = fld[1:0];
    r.wdata   = wd;
    r.e_pulse = ep[0];
    r.e_busy  = eb[0];
    r.e_done  = ed[0];
    r.e_step  = es[2:0];
    r.e_err   = ee[0];
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.loop_en   = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_step  = '0;
    bus.cfg_field = '0;
    bus.cfg_wdata = '0;
  endtask

  task automatic wr(input int step, input int fld, input int d);
    bus.cfg_we    = 1'b1;
    bus.cfg_step  = step[2:0];
    bus.cfg_field = fld[1:0];
    bus.cfg_wdata = d;
    @(posedge ACLK);
    @(negedge ACLK);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic wr_step(input int step, input int h, input int l, input int r);
    wr(step, 0, h);
    wr(step, 1, l);
    wr(step, 2, r);
  endtask

  // Row i is driven into edge i; its expectations are read back before edge i+1.
  task automatic run_vecs(input string nm, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < vt.size(); i++) begin
      bus.start     = vt[i].start;
      bus.abort     = vt[i].abort;
      bus.loop_en   = vt[i].loop_en;
      bus.cfg_we    = vt[i].we;
      bus.cfg_step  = '0;
      bus.cfg_field = vt[i].field;
      bus.cfg_wdata = vt[i].wdata;
      @(posedge ACLK);
      @(negedge ACLK);
      if (bus.busy === 1'b1) nbusy++;
      chk({nm, ".pulse"}, i, 32'(bus.pulse_out), 32'(vt[i].e_pulse));
      chk({nm, ".busy"},  i, 32'(bus.busy),      32'(vt[i].e_busy));
      chk({nm, ".done"},  i, 32'(bus.done),      32'(vt[i].e_done));
      chk({nm, ".step"},  i, 32'(bus.cur_step),  32'(vt[i].e_step));
      chk({nm, ".err"},   i, 32'(bus.cfg_err),   32'(vt[i].e_err));
    end
    idle_inputs();
    vt.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int nb;
    int wave[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    int mp[7]    = '{1, 0, 1, 1, 0, 0, 0};
    int ms[7]    = '{0, 0, 1, 1, 2, 2, 2};
    int lw[9]    = '{1, 1, 0, 0, 1, 1, 0, 0, 1};

    idle_inputs();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    chk("reset.pulse", 0, 32'(bus.pulse_out), 32'd0);
    chk("reset.busy",  0, 32'(bus.busy),      32'd0);
    chk("reset.done",  0, 32'(bus.done),      32'd0);
    chk("reset.step",  0, 32'(bus.cur_step),  32'd0);
    chk("reset.err",   0, 32'(bus.cfg_err),   32'd0);

    // Reset table is all terminators.
    vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("term0", nb);
    chk("term0.busy_cycles", 0, 32'(nb), 32'd1);

    // Upper data bits must be truncated away.
    wr(0, 0, 32'h0001_0003);
    wr(0, 1, 2);
    wr(0, 2, 32'h0000_0102);
    for (int i = 0; i < 10; i++) vt.push_back(v((i == 0) ? 1 : 0, 0, 0, 0, 0, 0, wave[i], 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("basic", nb);
    chk("basic.busy_cycles", 0, 32'(nb), 32'd10);

    wr_step(0, 1, 1, 1);
    wr_step(1, 2, 0, 1);
    wr_step(2, 0, 3, 1);
    for (int i = 0; i < 7; i++) vt.push_back(v((i == 0) ? 1 : 0, 0, 0, 0, 0, 0, mp[i], 1, 0, ms[i], 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("multi", nb);
    chk("multi.busy_cycles", 0, 32'(nb), 32'd7);

    // Start+abort together and abort alone in idle do nothing; then loop until aborted.
    wr_step(0, 2, 2, 1);
    wr(1, 2, 0);
    vt.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) vt.push_back(v((i == 0) ? 1 : 0, 0, 1, 0, 0, 0, lw[i], 1, 0, 0, 0));
    vt.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("loop_abort", nb);

    // Writes and a restart during a run are dropped; reserved field raises no error.
    vt.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 0, 7, 1, 1, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 1, 3, 9, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("busy_write", nb);

    for (int s = 0; s < 8; s++) wr_step(s, 1, 1, 1);
    bus.start = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    bus.start = 1'b0;
    nb = 0;
    for (int e = 1; e <= 16; e++) begin
      if (bus.busy === 1'b1) nb++;
      chk("full.pulse", e, 32'(bus.pulse_out), 32'(e % 2));
      chk("full.step",  e, 32'(bus.cur_step),  32'((e - 1) / 2));
      chk("full.done",  e, 32'(bus.done),      32'd0);
      @(posedge ACLK);
      @(negedge ACLK);
    end
    chk("full.busy_cycles", 0, 32'(nb), 32'd16);
    chk("full.end_busy",    17, 32'(bus.busy),     32'd0);
    chk("full.end_done",    17, 32'(bus.done),     32'd1);
    chk("full.end_step",    17, 32'(bus.cur_step), 32'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("full.done_clear",  18, 32'(bus.done),     32'd0);

    bus.start = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    bus.start = 1'b0;
    repeat (8) begin
      @(posedge ACLK);
      @(negedge ACLK);
    end
    chk("rst.pre_step",  9, 32'(bus.cur_step),  32'd4);
    chk("rst.pre_pulse", 9, 32'(bus.pulse_out), 32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("rst.pulse", 0, 32'(bus.pulse_out), 32'd0);
    chk("rst.busy",  0, 32'(bus.busy),      32'd0);
    chk("rst.step",  0, 32'(bus.cur_step),  32'd0);
    chk("rst.done",  0, 32'(bus.done),      32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Cleared table plus loop_en still ends as a single-cycle terminator run.
    vt.push_back(v(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("post_rst", nb);
    chk("post_rst.busy_cycles", 0, 32'(nb), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
